uart_bridge: RTL and testbench
==============================

# uart_bridge

Byte-level command responder between the UART pair and a 32-bit memory port. It parses frames from `uart_rx` output (`data`/`ready`), performs single-word reads or writes, and returns responses through `uart_tx` (`data`/`write`/`busy`). It is the board-side end of the host loader/debug link and replaces the direct rx→tx loopback in the top level.

## Interface
- `CLOCK_HZ`, 50000000, clock frequency; used only to derive the timeout default.
- `TIMEOUT_CLKS`, CLOCK_HZ/10, idle clocks allowed between bytes of one frame (100 ms).
- `clk`  in  1  system clock; the block uses one clock.
- `resetn`  in  1  reset, synchronous and active-low.
- `rx_ready`  in  1  one-cycle pulse; `rx_data` is valid in the same cycle.
- `rx_data`  in  8  received byte.
- `tx_busy`  in  1  transmitter busy; high from the cycle after `tx_write` until the stop bit is done.
- `tx_write`  out  1  one-cycle pulse that starts transmission of `tx_data`.
- `tx_data`  out  8  byte to send; held stable from the `tx_write` cycle until the next `tx_write`.
- `mem_addr`  out  32  word address as received; no alignment is applied.
- `mem_wdata`  out  32  write data.
- `mem_we`  out  1  one-cycle write strobe.
- `mem_re`  out  1  one-cycle read strobe; `mem_rdata` is valid exactly one cycle later.
- `mem_rdata`  in  32  read data.
- `active`  out  1  high while a frame is being received or answered.

## Operation
- Frame formats (all multi-byte fields little-endian):
  - Write: 0x57 'W', then A0..A3, then D0..D3. Response: ACK 0x06.
  - Read: 0x52 'R', then A0..A3. Response: R0..R3.
  - Any other first byte: response NAK 0x15. No memory access occurs.
- States:
  - IDLE: any byte moves to CMD_DECODE handling.
    - 'W' or 'R' → ADDR.
    - Other byte → SEND, with a 1-byte NAK.
  - ADDR: 4 bytes are shifted into `mem_addr` at byte lane = index.
    - After the 4th byte: 'W' → DATA, 'R' → MEM_RD.
  - DATA: 4 bytes are shifted into `mem_wdata`; after the 4th byte → MEM_WR.
  - MEM_WR: `mem_we` high for 1 cycle → SEND, with a 1-byte ACK.
  - MEM_RD: `mem_re` high for 1 cycle → RD_WAIT.
  - RD_WAIT: capture `mem_rdata` into the response buffer → SEND, 4 bytes.
  - SEND: byte counter indexes the response buffer.
    - Issue `tx_write` when the transmit guard allows (see Timing).
    - After the last byte → IDLE.
- `rx_ready` pulses while in MEM_WR, MEM_RD, RD_WAIT or SEND are dropped. No buffering; the host must wait for the response.
- Timeout: the counter clears on every accepted byte.
  - In ADDR or DATA, reaching TIMEOUT_CLKS → IDLE silently, with no response and no memory access.
  - The counter width is `$clog2(TIMEOUT_CLKS+1)`. The counter saturates and does not wrap.
- `active` = state != IDLE.
- `mem_addr` and `mem_wdata` hold their last values between frames.

## Timing
- Reset: all outputs 0 and the state is IDLE. `tx_data`, `mem_addr` and `mem_wdata` are also cleared to 0.
- Reset asserted mid-frame or mid-send: the block returns to IDLE on the next edge and the remaining response bytes are discarded. A byte already handed to `uart_tx` is not the bridge's concern.
- Write latency: D3 `rx_ready` at cycle N → `mem_we` at N+1 → earliest `tx_write`(0x06) at N+2.
- Read latency: A3 `rx_ready` at cycle N → `mem_re` at N+1 → `mem_rdata` sampled at N+2 → earliest `tx_write`(R0) at N+3.
- Transmit guard: `tx_write` is asserted only when `tx_busy`=0 and no `tx_write` was issued in the previous cycle. This covers `tx_busy` rising one cycle late.
- The 8-bit shift and lane placement are exact, with no sign extension.
- All strobes are single-cycle. `mem_we` and `mem_re` are never high together.

## Structure
- Shared package `uart_bridge_pkg`:
  - Command and response byte constants: CMD_WR 8'h57, CMD_RD 8'h52, RSP_ACK 8'h06, RSP_NAK 8'h15.
  - State enum typedef `bridge_state_t`.
- Single module; no sub-module is warranted. The timeout counter and the byte counters are inline.
- Top level: `uart_rx.ready/data` → `rx_ready/rx_data`; `tx_write/tx_data/tx_busy` ↔ `uart_tx.write/data/busy`.

## Test plan
- Write: feed 57 10 00 00 00 EF BE AD DE.
  - Expect one `mem_we` pulse with `mem_addr`=0x00000010 and `mem_wdata`=0xDEADBEEF.
  - Expect one transmitted byte, 0x06.
- Read: feed 52 10 00 00 00; memory model returns 0xCAFEF00D one cycle after `mem_re`.
  - Expect transmitted bytes 0D F0 FE CA in order, each only after `tx_busy` falls.
- Bad command: feed 0x41.
  - Expect a single 0x15, no `mem_we`/`mem_re`, and `active` back to 0.
- Timeout: feed 57 10 00, then idle for TIMEOUT_CLKS+5 cycles, then feed a full read frame for address 0x20.
  - Expect no response to the partial frame and correct read data for 0x20.
- Dropped bytes: during SEND of a read response, inject 3 `rx_ready` pulses.
  - Expect exactly 4 response bytes, the state returns to IDLE, and no extra memory access.
- Reset mid-response: assert `resetn`=0 for one cycle after the 2nd read-response byte.
  - Expect all outputs 0 on the next cycle, no further `tx_write`, and the next frame handled normally.

Source files
------------

// File: rtl/uart_bridge_pkg.sv
// uart_bridge_pkg: command/response bytes and FSM state type shared by the UART command bridge
package uart_bridge_pkg;
    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    typedef enum logic [2:0] {IDLE, ADDR, DATA, MEM_WR, MEM_RD, RD_WAIT, SEND} bridge_state_t;
endpackage

// File: rtl/uart_bridge.sv
// uart_bridge: parses UART byte frames into single-word memory reads/writes and sends the response
module uart_bridge
    import uart_bridge_pkg::*;
#(
    parameter int CLOCK_HZ     = 50000000,
    parameter int TIMEOUT_CLKS = CLOCK_HZ / 10
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rx_ready,
    input  logic [7:0]  rx_data,
    input  logic        tx_busy,
    output logic        tx_write,
    output logic [7:0]  tx_data,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata,
    output logic        active
);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);

    bridge_state_t state, state_n;
    logic          is_rd;
    logic [1:0]    idx;
    logic [1:0]    last;
    logic [TW-1:0] tcnt;
    logic [31:0]   rsp;
    logic [7:0]    tx_q;
    logic          wr_q;
    logic          timed_out;

    assign timed_out = tcnt == TW'(TIMEOUT_CLKS);
    // wr_q blocks back-to-back writes because tx_busy rises one cycle after tx_write
    assign tx_write  = state == SEND && !tx_busy && !wr_q;
    assign tx_data   = tx_write ? rsp[{idx, 3'b000} +: 8] : tx_q;
    assign mem_we    = state == MEM_WR;
    assign mem_re    = state == MEM_RD;
    assign active    = state != IDLE;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (rx_ready) state_n = (rx_data == CMD_WR || rx_data == CMD_RD) ? ADDR : SEND;
            ADDR:    state_n = (rx_ready && idx == 2'd3) ? (is_rd ? MEM_RD : DATA) : (!rx_ready && timed_out) ? IDLE : ADDR;
            DATA:    state_n = (rx_ready && idx == 2'd3) ? MEM_WR : (!rx_ready && timed_out) ? IDLE : DATA;
            MEM_WR:  state_n = SEND;
            MEM_RD:  state_n = RD_WAIT;
            RD_WAIT: state_n = SEND;
            SEND:    if (tx_write && idx == last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            is_rd     <= 1'b0;
            idx       <= '0;
            last      <= '0;
            tcnt      <= '0;
            rsp       <= '0;
            tx_q      <= '0;
            wr_q      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state <= state_n;
            wr_q  <= tx_write;
            tcnt  <= (rx_ready || !(state == ADDR || state == DATA)) ? '0 : timed_out ? tcnt : tcnt + 1'b1;
            if (tx_write) begin
                tx_q <= rsp[{idx, 3'b000} +: 8];
                idx  <= idx + 1'b1;
            end
            case (state)
                IDLE: if (rx_ready) begin
                    is_rd <= rx_data == CMD_RD;
                    idx   <= '0;
                    last  <= '0;
                    rsp   <= {24'h0, RSP_NAK};
                end
                ADDR: if (rx_ready) begin
                    mem_addr[{idx, 3'b000} +: 8] <= rx_data;
                    idx <= idx + 1'b1;
                end
                DATA: if (rx_ready) begin
                    mem_wdata[{idx, 3'b000} +: 8] <= rx_data;
                    idx <= idx + 1'b1;
                end
                MEM_WR: begin
                    rsp  <= {24'h0, RSP_ACK};
                    idx  <= '0;
                    last <= '0;
                end
                RD_WAIT: begin
                    rsp  <= mem_rdata;
                    idx  <= '0;
                    last <= 2'd3;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_bridge.sv
// tb_uart_bridge: directed frame tests for uart_bridge with busy-transmitter and memory models
module tb_uart_bridge;
    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        rx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_busy;
    logic        tx_write;
    logic [7:0]  tx_data;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata = 32'h0;
    logic        active;

    int total = 0;
    int bad = 0;
    int tx_n = 0;
    int we_n = 0;
    int re_n = 0;
    int guard_bad = 0;
    int both_bad = 0;
    int bcnt = 0;
    logic wr_prev = 1'b0;
    logic [7:0] tx_log [0:63];
    int base;
    int we_base;
    int re_base;

    uart_bridge #(.CLOCK_HZ(200), .TIMEOUT_CLKS(TO)) dut (
        .clk(clk), .resetn(resetn), .rx_ready(rx_ready), .rx_data(rx_data),
        .tx_busy(tx_busy), .tx_write(tx_write), .tx_data(tx_data),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .active(active)
    );

    always #5 clk = ~clk;

    assign tx_busy = bcnt != 0;

    always @(posedge clk) begin
        if (tx_write) bcnt <= 6;
        else if (bcnt != 0) bcnt <= bcnt - 1;
        mem_rdata <= !mem_re ? 32'h0 : mem_addr == 32'h10 ? 32'hCAFEF00D :
                     mem_addr == 32'h20 ? 32'h12345678 : 32'hBAD0BAD0;
    end

    always @(negedge clk) begin
        if (tx_write) begin
            if (tx_n < 64) tx_log[tx_n] <= tx_data;
            tx_n <= tx_n + 1;
            if (tx_busy || wr_prev) guard_bad <= guard_bad + 1;
        end
        wr_prev <= tx_write;
        if (mem_we) we_n <= we_n + 1;
        if (mem_re) re_n <= re_n + 1;
        if (mem_we && mem_re) both_bad <= both_bad + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic send_frame(input logic [71:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            send_byte(f[71-8*i -: 8]);
        end
    endtask

    task automatic wait_idle(input string tag);
        int i = 0;
        while (active && i < 300) begin
            @(negedge clk);
            i++;
        end
        chk(tag, 32'(active), 32'd0);
    endtask

    task automatic wait_tx(input int cnt, input string tag);
        int i = 0;
        while (tx_n - base < cnt && i < 300) begin
            @(negedge clk);
            i++;
        end
        chk(tag, 32'(tx_n - base >= cnt), 32'd1);
    endtask

    function automatic logic [31:0] log_word(input int b);
        return {tx_log[b+3], tx_log[b+2], tx_log[b+1], tx_log[b]};
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ctl", 32'({tx_write, mem_we, mem_re, active, tx_data}), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // write frame
        base = tx_n; we_base = we_n; re_base = re_n;
        send_frame(72'h57_10000000_EFBEADDE, 9);
        chk("wr_we", 32'(mem_we), 32'd1);
        chk("wr_addr", mem_addr, 32'h00000010);
        chk("wr_wdata", mem_wdata, 32'hDEADBEEF);
        @(negedge clk);
        chk("wr_txw", 32'(tx_write), 32'd1);
        chk("wr_ack", 32'(tx_data), 32'h06);
        wait_idle("wr_idle");
        chk("wr_ntx", tx_n - base, 32'd1);
        chk("wr_nwe", we_n - we_base, 32'd1);
        chk("wr_nre", re_n - re_base, 32'd0);

        // read frame
        repeat (10) @(negedge clk);
        base = tx_n; we_base = we_n; re_base = re_n;
        send_frame(72'h52_10000000_00000000, 5);
        chk("rd_re", 32'(mem_re), 32'd1);
        @(negedge clk);
        chk("rd_wait_txw", 32'(tx_write), 32'd0);
        @(negedge clk);
        chk("rd_txw", 32'(tx_write), 32'd1);
        chk("rd_b0", 32'(tx_data), 32'h0D);
        wait_idle("rd_idle");
        chk("rd_ntx", tx_n - base, 32'd4);
        chk("rd_data", log_word(base), 32'hCAFEF00D);
        chk("rd_nre", re_n - re_base, 32'd1);
        chk("rd_nwe", we_n - we_base, 32'd0);

        // bad command
        repeat (10) @(negedge clk);
        base = tx_n; we_base = we_n; re_base = re_n;
        send_byte(8'h41);
        chk("nak_txw", 32'(tx_write), 32'd1);
        chk("nak_byte", 32'(tx_data), 32'h15);
        wait_idle("nak_idle");
        repeat (10) @(negedge clk);
        chk("nak_ntx", tx_n - base, 32'd1);
        chk("nak_mem", (we_n - we_base) + (re_n - re_base), 32'd0);

        // timeout on partial write frame, then a read of 0x20
        base = tx_n; we_base = we_n; re_base = re_n;
        send_frame(72'h57_10_00_000000000000, 3);
        repeat (TO - 1) @(negedge clk);
        chk("to_still_active", 32'(active), 32'd1);
        repeat (6) @(negedge clk);
        chk("to_idle", 32'(active), 32'd0);
        chk("to_ntx", tx_n - base, 32'd0);
        send_frame(72'h52_20000000_00000000, 5);
        wait_idle("to_rd_idle");
        chk("to_rd_addr", mem_addr, 32'h00000020);
        chk("to_rd_ntx", tx_n - base, 32'd4);
        chk("to_rd_data", log_word(base), 32'h12345678);
        chk("to_mem", {re_n - re_base, we_n - we_base} == {32'd1, 32'd0} ? 32'd1 : 32'd0, 32'd1);

        // bytes arriving during SEND are dropped
        repeat (10) @(negedge clk);
        base = tx_n; we_base = we_n; re_base = re_n;
        send_frame(72'h52_10000000_00000000, 5);
        wait_tx(1, "drop_first");
        send_byte(8'h41);
        @(negedge clk);
        send_byte(8'h57);
        @(negedge clk);
        send_byte(8'h52);
        wait_idle("drop_idle");
        repeat (20) @(negedge clk);
        chk("drop_active", 32'(active), 32'd0);
        chk("drop_ntx", tx_n - base, 32'd4);
        chk("drop_data", log_word(base), 32'hCAFEF00D);
        chk("drop_nre", re_n - re_base, 32'd1);
        chk("drop_nwe", we_n - we_base, 32'd0);

        // reset after second response byte
        repeat (10) @(negedge clk);
        base = tx_n;
        send_frame(72'h52_20000000_00000000, 5);
        wait_tx(2, "rst_two");
        resetn = 1'b0;
        @(negedge clk);
        chk("mrst_ctl", 32'({tx_write, mem_we, mem_re, active, tx_data}), 32'd0);
        chk("mrst_addr", mem_addr, 32'd0);
        chk("mrst_wdata", mem_wdata, 32'd0);
        resetn = 1'b1;
        repeat (40) @(negedge clk);
        chk("mrst_ntx", tx_n - base, 32'd2);
        base = tx_n; we_base = we_n;
        send_frame(72'h57_20000000_44332211, 9);
        chk("post_we", 32'(mem_we), 32'd1);
        chk("post_wdata", mem_wdata, 32'h11223344);
        wait_idle("post_idle");
        chk("post_ntx", tx_n - base, 32'd1);
        chk("post_ack", 32'(tx_log[base]), 32'h06);
        chk("post_nwe", we_n - we_base, 32'd1);

        chk("tx_guard", guard_bad, 32'd0);
        chk("we_re_excl", both_bad, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
